// File: rtl/firtap_loader.sv
// Coefficient reload sequencer for a serially-loaded FIR tap chain.
// Streams NTAPS coefficients into the chain head, holds the filter, flushes, then reports.
module firtap_loader #(
  parameter int NTAPS     = 8,
  parameter int TW        = 16,
  parameter int FLUSH_LEN = 3
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_coef_valid,
  input  logic [TW-1:0] i_coef,
  output logic          o_coef_ready,
  output logic          o_tap_wr,
  output logic [TW-1:0] o_tap,
  output logic          o_hold,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  localparam int CW = $clog2(NTAPS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   coef_cnt_reg, coef_cnt_next;
  logic [7:0]      flush_cnt_reg, flush_cnt_next;
  logic [TW-1:0]   tap_reg;
  logic            tap_wr_reg;
  logic            err_reg;
  logic            active;
  logic            xfer;

  assign active = (state_reg == LOAD) || (state_reg == FLUSH);
  // Abort suppresses the handshake in its own cycle, so no tap write can follow it.
  assign xfer   = (state_reg == LOAD) && i_coef_valid && !i_abort;

  always_comb begin
    state_next     = state_reg;
    coef_cnt_next  = coef_cnt_reg;
    flush_cnt_next = flush_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (i_start && !i_abort) begin
          state_next    = LOAD;
          coef_cnt_next = '0;
        end
      end
      LOAD: begin
        if (i_abort) begin
          state_next = IDLE;
        end else if (xfer) begin
          coef_cnt_next = coef_cnt_reg + 1'b1;
          if (coef_cnt_reg == CW'(NTAPS - 1)) begin
            state_next     = FLUSH;
            flush_cnt_next = '0;
          end
        end
      end
      FLUSH: begin
        if (i_abort) begin
          state_next = IDLE;
        end else if (flush_cnt_reg == 8'(FLUSH_LEN - 1)) begin
          state_next = DONE;
        end else begin
          flush_cnt_next = flush_cnt_reg + 8'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg     <= IDLE;
      coef_cnt_reg  <= '0;
      flush_cnt_reg <= '0;
      tap_reg       <= '0;
      tap_wr_reg    <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      coef_cnt_reg  <= coef_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
      tap_wr_reg    <= xfer;
      err_reg       <= i_abort && active;
      if (xfer) begin
        tap_reg <= i_coef;
      end
    end
  end

  // Outputs are forced low for as long as reset is asserted, not just after its edge.
  assign o_coef_ready = !i_reset && (state_reg == LOAD) && !i_abort;
  assign o_hold       = !i_reset && active;
  assign o_busy       = !i_reset && active;
  assign o_done       = !i_reset && (state_reg == DONE);
  assign o_err        = !i_reset && err_reg;
  assign o_tap_wr     = !i_reset && tap_wr_reg;
  assign o_tap        = i_reset ? '0 : tap_reg;

endmodule

// File: tb/tb_firtap_loader.sv
// Directed and random reload scenarios for firtap_loader, checked each cycle
// against a phase/count reference model of the reload protocol.
module tb_firtap_loader;
  localparam int NTAPS     = 8;
  localparam int TW        = 16;
  localparam int FLUSH_LEN = 3;

  logic          i_clk = 1'b0;
  logic          i_reset, i_start, i_abort, i_coef_valid;
  logic [TW-1:0] i_coef;
  logic          o_coef_ready, o_tap_wr, o_hold, o_busy, o_done, o_err;
  logic [TW-1:0] o_tap;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: reload phase described by counts, not by an encoded state.
  bit            m_loading;
  int            m_accepted;
  int            m_flush_left;
  bit            m_done_now, m_err_now, m_wr_now;
  logic [TW-1:0] m_tap;
  int            done_seen, err_seen;

  firtap_loader #(.NTAPS(NTAPS), .TW(TW), .FLUSH_LEN(FLUSH_LEN)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
    .i_coef_valid(i_coef_valid), .i_coef(i_coef), .o_coef_ready(o_coef_ready),
    .o_tap_wr(o_tap_wr), .o_tap(o_tap), .o_hold(o_hold), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, compare every output, then advance the model across the edge.
  task automatic step(input bit rst, input bit start, input bit abort,
                      input bit valid, input logic [TW-1:0] coef);
    bit ready_e, active_e, xfer_e, was_loading, was_done;
    int was_flush;
    @(posedge i_clk);
    #1;
    i_reset = rst; i_start = start; i_abort = abort; i_coef_valid = valid; i_coef = coef;
    @(negedge i_clk);
    active_e = m_loading || (m_flush_left > 0);
    ready_e  = !rst && m_loading && !abort;
    xfer_e   = ready_e && valid;
    chk("coef_ready", 32'(o_coef_ready), 32'(ready_e));
    chk("hold",       32'(o_hold),       32'(!rst && active_e));
    chk("busy",       32'(o_busy),       32'(!rst && active_e));
    chk("done",       32'(o_done),       32'(!rst && m_done_now));
    chk("err",        32'(o_err),        32'(!rst && m_err_now));
    chk("tap_wr",     32'(o_tap_wr),     32'(!rst && m_wr_now));
    chk("tap",        32'(o_tap),        rst ? 32'd0 : 32'(m_tap));
    if (o_done === 1'b1) done_seen++;
    if (o_err === 1'b1)  err_seen++;
    if (rst) begin
      m_loading = 0; m_accepted = 0; m_flush_left = 0;
      m_done_now = 0; m_err_now = 0; m_wr_now = 0; m_tap = '0;
    end else begin
      was_loading = m_loading;
      was_flush   = m_flush_left;
      was_done    = m_done_now;
      m_wr_now    = xfer_e;
      if (xfer_e) m_tap = coef;
      m_err_now  = abort && active_e;
      m_done_now = 0;
      if (was_loading) begin
        if (abort) m_loading = 0;
        else if (xfer_e) begin
          m_accepted++;
          if (m_accepted == NTAPS) begin
            m_loading = 0;
            m_flush_left = FLUSH_LEN;
          end
        end
      end else if (was_flush > 0) begin
        if (abort) m_flush_left = 0;
        else begin
          m_flush_left--;
          if (m_flush_left == 0) m_done_now = 1;
        end
      end else if (!was_done) begin
        if (start && !abort) begin
          m_loading  = 1;
          m_accepted = 0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0);
  endtask

  initial begin
    int d0, e0;
    i_reset = 1; i_start = 0; i_abort = 0; i_coef_valid = 0; i_coef = '0;
    m_tap = '0;
    done_seen = 0; err_seen = 0;
    step(1, 0, 0, 0, '0);
    step(1, 1, 1, 1, 16'hbeef);

    // Basic reload: start, then coefficients 1..8 back to back.
    d0 = done_seen;
    step(0, 1, 0, 0, '0);
    for (int i = 1; i <= NTAPS; i++) step(0, 0, 0, 1, 16'(i));
    idle(6);
    chk("basic_done_count", 32'(done_seen - d0), 32'd1);

    // Valid toggling during LOAD.
    d0 = done_seen;
    step(0, 1, 0, 0, '0);
    for (int i = 1; i <= 2 * NTAPS; i++) step(0, 0, 0, i[0], 16'(16'h100 + i));
    idle(6);
    chk("toggle_done_count", 32'(done_seen - d0), 32'd1);

    // Abort after three transfers, with valid held high in the abort cycle.
    d0 = done_seen; e0 = err_seen;
    step(0, 1, 0, 0, '0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 16'(16'h200 + i));
    step(0, 0, 1, 1, 16'h2ff);
    idle(4);
    chk("abort_err_count", 32'(err_seen - e0), 32'd1);
    chk("abort_done_count", 32'(done_seen - d0), 32'd0);

    // Start held high throughout: one reload, then a new one right after DONE.
    d0 = done_seen;
    for (int i = 0; i < 2 * (NTAPS + FLUSH_LEN + 3); i++) step(0, 1, 0, 1, 16'($urandom));
    step(0, 0, 1, 0, '0);
    idle(3);
    chk("cont_start_done_count", 32'(done_seen - d0), 32'd2);

    // Reset during FLUSH, then a clean full reload.
    d0 = done_seen;
    step(0, 1, 0, 0, '0);
    for (int i = 0; i < NTAPS; i++) step(0, 0, 0, 1, 16'($urandom));
    step(0, 0, 0, 0, '0);
    step(1, 1, 0, 1, 16'h5a5a);
    idle(5);
    chk("flush_reset_done_count", 32'(done_seen - d0), 32'd0);
    step(0, 1, 0, 0, '0);
    for (int i = 0; i < NTAPS; i++) step(0, 0, 0, 1, 16'($urandom));
    idle(6);
    chk("reload_after_reset_done", 32'(done_seen - d0), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 6), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
